// File: rtl/a3_pkg.sv
// Shared regbank constants and the write-port bundle type.
package a3_pkg;

  localparam int REG_SEL_W  = 6;
  localparam int REG_DATA_W = 64;

  typedef struct packed {
    logic                  we;
    logic [REG_SEL_W-1:0]  sel;
    logic [REG_DATA_W-1:0] val;
  } regbank_wr_t;

endpackage

// File: rtl/regbank_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int best_d;
  int best_i;
  int d;

  // Rank each requester by its distance from ptr; works for non-power-of-two NREQ.
  always_comb begin
    best_d = NREQ;
    best_i = 0;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
      if (req[i] && d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    any = (best_d < NREQ);
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      gnt[i] = any && (i == best_i);
    idx = PTR_W'(best_i);
  end

endmodule

// File: rtl/regbank_wr_arb.sv
// Round-robin arbiter for the single regbank write port, registered output stage
// plus a saturating contention counter.
module regbank_wr_arb
  import a3_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int SEL_W  = REG_SEL_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SEL_W-1:0]    req_sel,
  input  logic [NREQ*DATA_W-1:0]   req_val,
  output logic [NREQ-1:0]          req_ready,
  output logic                     regbank_we,
  output logic [SEL_W-1:0]         regbank_sel,
  output logic [DATA_W-1:0]        regbank_val,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_gnt;
  logic              pick_any;
  logic [NREQ-1:0]   req_elig;
  logic [SEL_W-1:0]  sel_mux;
  logic [DATA_W-1:0] val_mux;
  logic              conflict;

  assign req_elig = req_valid & {NREQ{~stall}};

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req (req_elig),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant is held off while reset is asserted so no requester sees a phantom accept.
  assign req_ready = reset ? pick_gnt : '0;
  assign conflict  = ($countones(req_valid) >= 2);

  always_comb begin
    sel_mux = '0;
    val_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_mux = req_sel[i*SEL_W +: SEL_W];
        val_mux = req_val[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regbank_we   <= 1'b0;
      regbank_sel  <= '0;
      regbank_val  <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      regbank_we <= pick_any;
      if (pick_any) begin
        regbank_sel <= sel_mux;
        regbank_val <= val_mux;
        rr_ptr      <= (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + PTR_W'(1);
      end
      if (conflict && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Bench for regbank_wr_arb: reference model checked every cycle plus directed literals.
module tb_regbank_wr_arb;

  localparam int NREQ   = 3;
  localparam int SEL_W  = 6;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic                   clk;
  logic                   reset;
  logic                   stall;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*SEL_W-1:0]  req_sel;
  logic [NREQ*DATA_W-1:0] req_val;
  logic [NREQ-1:0]        req_ready;
  logic                   regbank_we;
  logic [SEL_W-1:0]       regbank_sel;
  logic [DATA_W-1:0]      regbank_val;
  logic [CNT_W-1:0]       conflict_cnt;

  logic [SEL_W-1:0]  sel_a [NREQ];
  logic [DATA_W-1:0] val_a [NREQ];

  int n_cmp  = 0;
  int n_fail = 0;

  regbank_wr_arb #(.NREQ(NREQ), .SEL_W(SEL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_val      (req_val),
    .req_ready    (req_ready),
    .regbank_we   (regbank_we),
    .regbank_sel  (regbank_sel),
    .regbank_val  (regbank_val),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_sel = '0;
    req_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_sel[i*SEL_W +: SEL_W]   = sel_a[i];
      req_val[i*DATA_W +: DATA_W] = val_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan from the pointer with modulo arithmetic, take the first valid.
  function automatic int grant_of(input logic [NREQ-1:0] v, input logic st, input int p);
    if (st) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  int                m_ptr;
  int                m_g;
  logic              m_we;
  logic [SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0] m_val;
  int                m_cnt;
  logic [NREQ-1:0]   m_rdy;

  assign m_g   = grant_of(req_valid, stall, m_ptr);
  assign m_rdy = (reset && m_g >= 0) ? NREQ'(1 << m_g) : '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr <= 0; m_we <= 1'b0; m_sel <= '0; m_val <= '0; m_cnt <= 0;
    end else begin
      m_we <= (m_g >= 0);
      if (m_g >= 0) begin
        m_sel <= sel_a[m_g];
        m_val <= val_a[m_g];
        m_ptr <= (m_g + 1) % NREQ;
      end
      if ($countones(req_valid) >= 2 && m_cnt < (1 << CNT_W) - 1)
        m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_ready", 64'(req_ready), 64'(m_rdy));
    chk("m_we",    64'(regbank_we), 64'(m_we));
    chk("m_sel",   64'(regbank_sel), 64'(m_sel));
    chk("m_val",   regbank_val, m_val);
    chk("m_cnt",   64'(conflict_cnt), 64'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] ord [6];

  initial begin
    ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset = 1'b0; stall = 1'b0; req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin sel_a[i] = '0; val_a[i] = '0; end

    #2;
    chk("rst_we",  64'(regbank_we), 64'd0);
    chk("rst_sel", 64'(regbank_sel), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'd0);
    step(); step();
    reset = 1'b1;

    // reset dropped while an accepted write is sitting in the output register
    step();
    req_valid = 3'b111;
    sel_a[0] = 6'd1; sel_a[1] = 6'd2; sel_a[2] = 6'd3;
    val_a[0] = 64'h11; val_a[1] = 64'h22; val_a[2] = 64'h33;
    #1 chk("pre_rst_rdy", 64'(req_ready), 64'b001);
    @(posedge clk); #2;
    chk("pre_rst_we", 64'(regbank_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",  64'(regbank_we), 64'd0);
    chk("mid_rst_rdy", 64'(req_ready), 64'd0);
    chk("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_we", 64'(regbank_we), 64'd0);

    // all three valid from pointer 0
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_order", 64'(req_ready), 64'(ord[k]));
      @(posedge clk); #1;
      chk("rr_we",  64'(regbank_we), 64'd1);
      chk("rr_sel", 64'(regbank_sel), 64'(k % 3 + 1));
    end

    // wrap on a non-power-of-two count
    req_valid = 3'b010;
    #1 chk("wrap_g1", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b101;
    #1 chk("wrap_g2", 64'(req_ready), 64'b100);
    step();
    #1 chk("wrap_g0", 64'(req_ready), 64'b001);
    step();

    // single writer
    req_valid = 3'b010; sel_a[1] = 6'd5; val_a[1] = 64'hDEAD_BEEF;
    #1 chk("single_rdy", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    chk("single_we",  64'(regbank_we), 64'd1);
    chk("single_sel", 64'(regbank_sel), 64'd5);
    chk("single_val", regbank_val, 64'hDEAD_BEEF);
    step();
    chk("single_we_off", 64'(regbank_we), 64'd0);

    // stall with an accepted write already in the output register
    req_valid = 3'b001; sel_a[0] = 6'd9; val_a[0] = 64'h123;
    #1 chk("stall_pre_rdy", 64'(req_ready), 64'b001);
    step();
    stall = 1'b1; sel_a[0] = 6'd10; val_a[0] = 64'h456;
    #1;
    chk("stall_rdy",   64'(req_ready), 64'd0);
    chk("stall_we",    64'(regbank_we), 64'd1);
    chk("stall_sel",   64'(regbank_sel), 64'd9);
    chk("stall_val",   regbank_val, 64'h123);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("stall_hold_rdy", 64'(req_ready), 64'd0);
      chk("stall_hold_we",  64'(regbank_we), 64'd0);
    end
    stall = 1'b0;
    #1 chk("unstall_rdy", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    chk("unstall_we",  64'(regbank_we), 64'd1);
    chk("unstall_sel", 64'(regbank_sel), 64'd10);
    chk("unstall_val", regbank_val, 64'h456);

    // counter saturation, stall toggling to show it is ignored
    req_valid = 3'b011;
    for (int k = 0; k < 20; k++) begin
      stall = k[0];
      step();
    end
    req_valid = '0; stall = 1'b0;
    chk("cnt_sat", 64'(conflict_cnt), 64'd15);
    step();
    chk("cnt_hold", 64'(conflict_cnt), 64'd15);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
